// File: rtl/sec_decoder_location_param.sv
// sec_decoder_location_param: sequential Hamming SEC decoder with a LANES-wide iterative error-location search.
// Optional build macro SEC_DED_EN adds an overall-parity bit (W MSB) for double-error detection.
`default_nettype none

module sec_decoder_location_param #(
    parameter int DATA_BITS = 24,
    parameter int PAR_BITS  = 5,
    parameter int LANES     = 4,
    localparam int HAM_BITS = DATA_BITS + PAR_BITS,
`ifdef SEC_DED_EN
    localparam int CW_BITS  = HAM_BITS + 1
`else
    localparam int CW_BITS  = HAM_BITS
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW_BITS-1:0]   W,
    output logic                 found,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] N,
    output logic                 err_corrected,
    output logic                 err_uncorrectable,
    output logic [PAR_BITS-1:0]  err_pos
);

    // Search pointer must hold HAM_BITS+LANES and also the zero-extended syndrome.
    localparam int POS_RAW = $clog2(HAM_BITS + LANES + 1);
    localparam int POS_W   = (POS_RAW > PAR_BITS) ? POS_RAW : PAR_BITS + 1;

    localparam logic [POS_W-1:0] C_HAM_POS = POS_W'(HAM_BITS);
    localparam logic [POS_W-1:0] C_LANES   = POS_W'(LANES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SYND   = 2'd1;
    localparam logic [1:0] S_SEARCH = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]           r_state;
    logic [CW_BITS-1:0]   r_cw;
    logic [PAR_BITS-1:0]  r_synd;
    logic                 r_synd_vld;
    logic [POS_W-1:0]     r_pos;
    logic [DATA_BITS-1:0] r_n;
    logic                 r_corr;
    logic                 r_unc;
    logic [PAR_BITS-1:0]  r_err_pos;
`ifdef SEC_DED_EN
    logic                 r_par;
    logic                 w_par;
`endif

    logic [PAR_BITS-1:0]  w_synd;
    logic [POS_W-1:0]     w_synd_ext;
    logic                 w_hit;
    logic                 w_fix_en;
    logic [DATA_BITS-1:0] w_data;

    always_comb begin
        w_synd = '0;
        for (int i = 1; i <= HAM_BITS; i++) begin
            if (r_cw[i-1]) begin
                w_synd = w_synd ^ PAR_BITS'(i);
            end
        end
    end

`ifdef SEC_DED_EN
    assign w_par = ^r_cw;
`endif

    assign w_synd_ext = {{(POS_W-PAR_BITS){1'b0}}, r_synd};

    // Lane l examines position r_pos+l; lanes past the Hamming range never match.
    always_comb begin
        w_hit = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (((r_pos + POS_W'(l)) == w_synd_ext) &&
                ((r_pos + POS_W'(l)) <= C_HAM_POS)) begin
                w_hit = 1'b1;
            end
        end
    end

    // Correction is only applied when the search hits; the flip targets position r_synd.
    assign w_fix_en = (r_state == S_SEARCH);

    for (genvar p = 1; p <= HAM_BITS; p++) begin : g_map
        if ((p & (p - 1)) != 0) begin : g_data
            assign w_data[p - 1 - $clog2(p + 1)] =
                r_cw[p-1] ^ (w_fix_en && (r_synd == PAR_BITS'(p)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cw       <= '0;
            r_synd     <= '0;
            r_synd_vld <= 1'b0;
            r_pos      <= '0;
            r_n        <= '0;
            r_corr     <= 1'b0;
            r_unc      <= 1'b0;
            r_err_pos  <= '0;
`ifdef SEC_DED_EN
            r_par      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cw       <= W;
                        r_synd_vld <= 1'b0;
                        r_corr     <= 1'b0;
                        r_unc      <= 1'b0;
                        r_err_pos  <= '0;
                        r_state    <= S_SYND;
                    end
                end
                S_SYND: begin
                    if (!r_synd_vld) begin
                        r_synd     <= w_synd;
                        r_synd_vld <= 1'b1;
`ifdef SEC_DED_EN
                        r_par      <= w_par;
`endif
                    end else begin
                        r_pos <= POS_W'(1);
                        r_n   <= w_data;
`ifdef SEC_DED_EN
                        if ((r_synd != '0) && !r_par) begin
                            r_unc   <= 1'b1;
                            r_state <= S_DONE;
                        end else if (r_synd == '0) begin
                            // Only the overall-parity bit can be wrong here.
                            r_corr  <= r_par;
                            r_state <= S_DONE;
                        end else if (w_synd_ext > C_HAM_POS) begin
                            r_unc   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SEARCH;
                        end
`else
                        if (r_synd == '0) begin
                            r_state <= S_DONE;
                        end else if (w_synd_ext > C_HAM_POS) begin
                            r_unc   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SEARCH;
                        end
`endif
                    end
                end
                S_SEARCH: begin
                    if (w_hit) begin
                        r_n       <= w_data;
                        r_corr    <= 1'b1;
                        r_err_pos <= r_synd;
                        r_state   <= S_DONE;
                    end else begin
                        r_pos <= r_pos + C_LANES;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready          = (r_state == S_IDLE);
    assign found             = (r_state == S_DONE);
    assign N                 = r_n;
    assign err_corrected     = r_corr;
    assign err_uncorrectable = r_unc;
    assign err_pos           = r_err_pos;

endmodule

`default_nettype wire

// File: tb/tb_sec_decoder_location_param.sv
// tb_sec_decoder_location_param: randomized bench for sec_decoder_location_param against a behavioural Hamming model.
// Honours SEC_DED_EN to match the codeword width of the design build.
`default_nettype none

module tb_sec_decoder_location_param;

    localparam int DATA_BITS = 24;
    localparam int PAR_BITS  = 5;
    localparam int LANES     = 4;
    localparam int HAM       = DATA_BITS + PAR_BITS;
`ifdef SEC_DED_EN
    localparam int CW        = HAM + 1;
`else
    localparam int CW        = HAM;
`endif
    localparam int RES_W     = DATA_BITS + 2 + PAR_BITS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [CW-1:0]        W = '0;
    logic                 found;
    logic                 out_ready = 1'b0;
    logic [DATA_BITS-1:0] N;
    logic                 err_corrected;
    logic                 err_uncorrectable;
    logic [PAR_BITS-1:0]  err_pos;

    int tests_run = 0;
    int tests_failed = 0;

    sec_decoder_location_param #(
        .DATA_BITS(DATA_BITS),
        .PAR_BITS (PAR_BITS),
        .LANES    (LANES)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .W                (W),
        .found            (found),
        .out_ready        (out_ready),
        .N                (N),
        .err_corrected    (err_corrected),
        .err_uncorrectable(err_uncorrectable),
        .err_pos          (err_pos)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] encode(input logic [DATA_BITS-1:0] data);
        logic [CW-1:0] cw = '0;
        int d = 0;
        int s = 0;
        for (int p = 1; p <= HAM; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = data[d];
                if (data[d]) s = s ^ p;
                d++;
            end
        end
        for (int j = 0; j < PAR_BITS; j++) cw[(1 << j) - 1] = s[j];
`ifdef SEC_DED_EN
        cw[CW-1] = ^cw[HAM-1:0];
`endif
        return cw;
    endfunction

    // Decode from first principles: syndrome, overall parity, range rule, then data extraction.
    function automatic void model(input logic [CW-1:0] cw, output logic [RES_W-1:0] res, output int lat);
        logic [CW-1:0]        fixed = cw;
        logic [DATA_BITS-1:0] n = '0;
        logic                 c = 1'b0;
        logic                 u = 1'b0;
        int                   pos = 0;
        int                   s = 0;
        int                   d = 0;
        bit                   par = ^cw;
        bit                   search = 0;
        for (int i = 1; i <= HAM; i++) if (cw[i-1]) s = s ^ i;
        lat = 2;
`ifdef SEC_DED_EN
        if (s != 0 && !par) u = 1'b1;
        else if (s == 0 && par) c = 1'b1;
        else if (s > HAM) u = 1'b1;
        else if (s != 0) search = 1;
`else
        if (par) d = 0;
        if (s > HAM) u = 1'b1;
        else if (s != 0) search = 1;
`endif
        if (search) begin
            fixed[s-1] = ~fixed[s-1];
            c = 1'b1;
            pos = s;
            lat = 2 + (s + LANES - 1) / LANES;
        end
        d = 0;
        for (int p = 1; p <= HAM; p++) begin
            if ((p & (p - 1)) != 0) begin
                n[d] = fixed[p-1];
                d++;
            end
        end
        res = {n, c, u, PAR_BITS'(pos)};
    endfunction

    // Drives one codeword; returns latency (accept edge to found) and the result seen at found.
    task automatic send(input logic [CW-1:0] cw, input bit rdy, output int lat, output logic [RES_W-1:0] res);
        int g = 0;
        W = cw;
        in_valid = 1'b1;
        out_ready = rdy;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!found && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = {N, err_corrected, err_uncorrectable, err_pos};
        if (rdy && found) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [CW-1:0] flip(input logic [CW-1:0] cw, input int p);
        logic [CW-1:0] r = cw;
        if (p > 0) r[p-1] = ~r[p-1];
        return r;
    endfunction

    task automatic test_reset();
        logic [RES_W+1:0] obs;
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        obs = {in_ready, found, N, err_corrected, err_uncorrectable, err_pos};
        tests_run++;
        if (obs !== {1'b1, 1'b0, {RES_W{1'b0}}}) begin
            tests_failed++;
            $display("FAIL reset_hold: got %h required %h", obs, {1'b1, 1'b0, {RES_W{1'b0}}});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        obs = {in_ready, found, N, err_corrected, err_uncorrectable, err_pos};
        tests_run++;
        if (obs !== {1'b1, 1'b0, {RES_W{1'b0}}}) begin
            tests_failed++;
            $display("FAIL reset_release: got %h required %h", obs, {1'b1, 1'b0, {RES_W{1'b0}}});
        end
    endtask

    task automatic test_plan_vectors();
        int f1[4] = '{0, 7, 29, 14};
        int f2[4] = '{0, 0, 0, 16};
        int el[4] = '{2, 4, 10, 2};
        logic [RES_W-1:0] er[4] = '{{24'hFFFFFF, 2'b00, 5'd0}, {24'hFFFFFF, 2'b10, 5'd7},
                                    {24'hFFFFFF, 2'b10, 5'd29}, {24'hFFFDFF, 2'b01, 5'd0}};
        logic [CW-1:0]    cw;
        logic [RES_W-1:0] res;
        int               lat;
        for (int k = 0; k < 4; k++) begin
            cw = flip(flip(encode(24'hFFFFFF), f1[k]), f2[k]);
            send(cw, 1'b1, lat, res);
            tests_run++;
            if (lat !== el[k]) begin
                tests_failed++;
                $display("FAIL plan%0d latency: got %0d required %0d", k, lat, el[k]);
            end
            tests_run++;
            if (res !== er[k]) begin
                tests_failed++;
                $display("FAIL plan%0d result: got %h required %h", k, res, er[k]);
            end
        end
    endtask

    task automatic test_single_errors();
        logic [DATA_BITS-1:0] data;
        logic [CW-1:0]        cw;
        logic [RES_W-1:0]     res, exp_res;
        int                   lat, exp_lat;
        for (int p = 1; p <= CW; p++) begin
            data = DATA_BITS'($urandom);
            cw = flip(encode(data), p);
            model(cw, exp_res, exp_lat);
            send(cw, 1'b1, lat, res);
            tests_run++;
            if (lat !== exp_lat || res !== exp_res) begin
                tests_failed++;
                $display("FAIL single_pos%0d: got lat=%0d res=%h required lat=%0d res=%h",
                         p, lat, res, exp_lat, exp_res);
            end
        end
    endtask

    task automatic test_random();
        logic [CW-1:0]    cw;
        logic [RES_W-1:0] res, exp_res;
        int               lat, exp_lat, nerr, p1, p2;
        for (int it = 0; it < 40; it++) begin
            cw = encode(DATA_BITS'($urandom));
            nerr = $urandom_range(0, 2);
            p1 = $urandom_range(1, CW);
            p2 = $urandom_range(1, CW - 1);
            if (p2 >= p1) p2++;
            if (nerr >= 1) cw = flip(cw, p1);
            if (nerr == 2) cw = flip(cw, p2);
            model(cw, exp_res, exp_lat);
            send(cw, 1'b1, lat, res);
            tests_run++;
            if (lat !== exp_lat || res !== exp_res) begin
                tests_failed++;
                $display("FAIL random%0d (nerr=%0d p=%0d,%0d): got lat=%0d res=%h required lat=%0d res=%h",
                         it, nerr, p1, p2, lat, res, exp_lat, exp_res);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [CW-1:0]    cw;
        logic [RES_W-1:0] res, exp_res, now;
        int               lat, exp_lat;
        cw = flip(encode(DATA_BITS'($urandom)), $urandom_range(1, CW));
        model(cw, exp_res, exp_lat);
        send(cw, 1'b0, lat, res);
        tests_run++;
        if (lat !== exp_lat || res !== exp_res) begin
            tests_failed++;
            $display("FAIL bp_first: got lat=%0d res=%h required lat=%0d res=%h", lat, res, exp_lat, exp_res);
        end
        // A competing codeword must not be accepted while the result is pending.
        W = encode(DATA_BITS'($urandom));
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            now = {N, err_corrected, err_uncorrectable, err_pos};
            tests_run++;
            if ({found, in_ready, now} !== {1'b1, 1'b0, exp_res}) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got found=%b in_ready=%b res=%h required 1 0 %h",
                         c, found, in_ready, now, exp_res);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({found, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL bp_release: got found=%b in_ready=%b required found=0 in_ready=1", found, in_ready);
        end
    endtask

    task automatic test_reset_mid_search();
        logic [CW-1:0]    cw;
        logic [RES_W-1:0] res, exp_res;
        logic [RES_W+1:0] obs;
        int               lat, exp_lat, seen;
        W = flip(encode(DATA_BITS'($urandom)), 29);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        obs = {in_ready, found, N, err_corrected, err_uncorrectable, err_pos};
        tests_run++;
        if (obs !== {1'b1, 1'b0, {RES_W{1'b0}}}) begin
            tests_failed++;
            $display("FAIL midrst_values: got %h required %h", obs, {1'b1, 1'b0, {RES_W{1'b0}}});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (found) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL midrst_no_found: got %0d found cycles required 0", seen);
        end
        cw = flip(encode(DATA_BITS'($urandom)), $urandom_range(1, CW));
        model(cw, exp_res, exp_lat);
        send(cw, 1'b1, lat, res);
        tests_run++;
        if (lat !== exp_lat || res !== exp_res) begin
            tests_failed++;
            $display("FAIL midrst_next: got lat=%0d res=%h required lat=%0d res=%h", lat, res, exp_lat, exp_res);
        end
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_single_errors();
        test_random();
        test_backpressure();
        test_reset_mid_search();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
